vga_timing_pipeline: RTL and testbench
======================================

// Module: vga_timing_pipeline
// PURPOSE
//  Parametrised VGA timing and output stage for any resolution; 640x480@60 is the default.
//  Generates h/v counters and a pixel request (row/col) to the drawer, then accepts its colour PIXEL_LATENCY cycles later.
//  Delays syncs/blank to stay aligned with that colour, forces black outside the active area, and registers all pins.
//  Sits between the PLL pixel clock and the drawer; replaces the fixed signal-generator + blanking-register pair.
// PARAMETERS
//  H_ACTIVE 640 visible px/line | H_FP 16 | H_SYNC 96 | H_BP 48 (H_TOTAL = sum = 800)
//  V_ACTIVE 480 visible lines | V_FP 10 | V_SYNC 2 | V_BP 33 (V_TOTAL = sum = 525)
//  H_SYNC_POL 0, V_SYNC_POL 0   active level of hsync/vsync (0 = active low)
//  COLOR_BITS 4                 bits per colour channel
//  PIXEL_LATENCY 1              drawer cycles from request to valid pixel data; range 0..8
// PORTS
//  pixel_clk     in   1            pixel clock, only clock
//  reset         in   1            synchronous, active-high
//  req_col       out  16           column of the current pixel request (= h_cnt)
//  req_row       out  16           row of the current pixel request (= v_cnt)
//  req_active    out  1            request lies in the visible area
//  frame_start   out  1            1-cycle pulse when h_cnt=0 and v_cnt=0 (request side)
//  line_start    out  1            1-cycle pulse when h_cnt=0 (request side)
//  pix_red/green/blue in COLOR_BITS  drawer colour, valid PIXEL_LATENCY cycles after its request
//  hsync, vsync  out  1            registered sync pins
//  vga_red/green/blue out COLOR_BITS registered colour pins
// BEHAVIOUR
//  - Clock and reset: one clock (pixel_clk); reset is synchronous and active-high.
//  - Counters: h_cnt runs 0..H_TOTAL-1; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
//    v_cnt wraps 0 after V_TOTAL-1 on the same cycle that h_cnt wraps.
//    Both counters are unsigned 16-bit; upper bits stay zero.
//  - Request side is combinational from the counters: req_col, req_row, req_active = (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE).
//    line_start = (h_cnt==0). frame_start = line_start && (v_cnt==0).
//  - hs_raw = 1 for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. vs_raw is the same rule over v_cnt.
//  - Alignment: {hs_raw, vs_raw, req_active} pass through a PIXEL_LATENCY-deep shift register.
//    The delayed active flag gates pix_*; the result is registered into vga_*.
//    hsync = delayed hs_raw ? H_SYNC_POL : ~H_SYNC_POL, registered in the same stage (vsync likewise).
//    Pins therefore show the pixel for counter value at cycle t on cycle t+PIXEL_LATENCY+1.
//    Sync and colour pins are always mutually aligned.
//  - Blanking: when the delayed active flag is 0, vga_* = 0 regardless of pix_*.
//  - Reset values: h_cnt = v_cnt = 0; vga_* = 0; hsync = ~H_SYNC_POL; vsync = ~V_SYNC_POL.
//    The delay line is cleared to inactive/blank.
//  - Reset mid-frame: on the next edge, counters return to (0,0) and pins go inactive/black.
//    Stale delay-line contents are discarded. After release, the first frame_start is asserted in the first cycle.
//  - PIXEL_LATENCY=0: the delay line is bypassed and only the output register remains (latency 1).
// CONFIGURATION
//  VGA_TEST_PATTERN_EN defined: adds input tp_sel (1 bit).
//    With tp_sel=1, pix_* are ignored and 8 vertical bars of width H_ACTIVE/8 are generated from the delayed column.
//    Bar order: white, yellow, cyan, green, magenta, red, blue, black (full-scale channels).
//    Bars obey the same alignment and blanking rules. tp_sel is sampled per pixel.
//  VGA_TEST_PATTERN_EN undefined: tp_sel does not exist and pix_* are always used.
// STRUCTURE
//  - Package vga_pkg: the default 640x480@60 timing localparams.
//    Also typedef vga_rgb_t (struct of three COLOR_BITS channels) and the test-bar colour table.
//  - Sub-module vga_delay_line #(WIDTH, DEPTH): synchronous-reset shift register used for the sync/active alignment.
// TESTING
//  1. Reset held 3 cycles, then released -> hsync=vsync=1, vga_*=0 during reset; frame_start=1 in the first cycle after release.
//  2. Defaults, free run -> hsync low exactly 96 cycles every 800.
//     The falling edge comes 656+PIXEL_LATENCY+1 cycles after line_start.
//  3. Defaults, free run -> vsync low exactly 2 lines (1600 cycles) every 525 lines; frame_start period = 420000 cycles.
//  4. PIXEL_LATENCY=2, drawer model returns pix_red = req_col[3:0] 2 cycles late ->
//     vga_red at the pin matches the column for all 640 pixels; 0 for h_cnt 640..799.
//  5. pix_*=4'hF constantly -> vga_* = 0 at every pin cycle whose source v_cnt>=480 or h_cnt>=640.
//  6. Reset at h_cnt=300, v_cnt=200 -> next cycle: pins inactive/black; after release, line_start at h_cnt=0 with no stale pixels emitted.
//     With VGA_TEST_PATTERN_EN and tp_sel=1: pixel col 0 = FFF, col 80 = FF0, col 600 = 000.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, colour bundle type and test-bar table.
// Shared by vga_timing_pipeline (VGA_TEST_PATTERN_EN enables the bar table use).
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE      = 640;
    localparam int unsigned VGA_H_FP          = 16;
    localparam int unsigned VGA_H_SYNC        = 96;
    localparam int unsigned VGA_H_BP          = 48;

    localparam int unsigned VGA_V_ACTIVE      = 480;
    localparam int unsigned VGA_V_FP          = 10;
    localparam int unsigned VGA_V_SYNC        = 2;
    localparam int unsigned VGA_V_BP          = 33;

    localparam int unsigned VGA_COLOR_BITS    = 4;
    localparam int unsigned VGA_PIXEL_LATENCY = 1;

    typedef struct packed {
        logic [VGA_COLOR_BITS-1:0] red;
        logic [VGA_COLOR_BITS-1:0] green;
        logic [VGA_COLOR_BITS-1:0] blue;
    } vga_rgb_t;

    // Channel enables {r,g,b} per bar, index 0 = leftmost (white .. black)
    localparam logic [7:0][2:0] VGA_BAR_MASK = {
        3'b000, 3'b001, 3'b100, 3'b101,
        3'b010, 3'b011, 3'b110, 3'b111
    };

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage shift register, synchronous active-high clear.
// Realigns the sync/active flags with drawer data that arrives DEPTH cycles late.
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] sr_q;
    logic [DEPTH-1:0][WIDTH-1:0] sr_d;

    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = din;
        for (int i = 1; i < int'(DEPTH); i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_pipeline.sv
// vga_timing_pipeline: h/v counters, drawer request, latency-matched sync/colour pins.
// Defining VGA_TEST_PATTERN_EN adds input tp_sel and an internal 8-bar test pattern.
module vga_timing_pipeline
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE      = VGA_H_ACTIVE,
    parameter int unsigned H_FP          = VGA_H_FP,
    parameter int unsigned H_SYNC        = VGA_H_SYNC,
    parameter int unsigned H_BP          = VGA_H_BP,
    parameter int unsigned V_ACTIVE      = VGA_V_ACTIVE,
    parameter int unsigned V_FP          = VGA_V_FP,
    parameter int unsigned V_SYNC        = VGA_V_SYNC,
    parameter int unsigned V_BP          = VGA_V_BP,
    parameter bit          H_SYNC_POL    = 1'b0,
    parameter bit          V_SYNC_POL    = 1'b0,
    parameter int unsigned COLOR_BITS    = VGA_COLOR_BITS,
    parameter int unsigned PIXEL_LATENCY = VGA_PIXEL_LATENCY
) (
    input  logic                  pixel_clk,
    input  logic                  reset,
    output logic [15:0]           req_col,
    output logic [15:0]           req_row,
    output logic                  req_active,
    output logic                  frame_start,
    output logic                  line_start,
    input  logic [COLOR_BITS-1:0] pix_red,
    input  logic [COLOR_BITS-1:0] pix_green,
    input  logic [COLOR_BITS-1:0] pix_blue,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                  tp_sel,
`endif
    output logic                  hsync,
    output logic                  vsync,
    output logic [COLOR_BITS-1:0] vga_red,
    output logic [COLOR_BITS-1:0] vga_green,
    output logic [COLOR_BITS-1:0] vga_blue
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_VIS    = 16'(H_ACTIVE);
    localparam logic [15:0] V_VIS    = 16'(V_ACTIVE);
    localparam logic [15:0] HS_FIRST = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_LAST  = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [15:0] VS_FIRST = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_LAST  = 16'(V_ACTIVE + V_FP + V_SYNC - 1);

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned DLY_W = 19;
    localparam logic [15:0] BAR_W = 16'(H_ACTIVE / 8);
`else
    localparam int unsigned DLY_W = 3;
`endif

    logic [15:0] h_cnt_q;
    logic [15:0] h_cnt_d;
    logic [15:0] v_cnt_q;
    logic [15:0] v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q + 16'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + 16'd1;
            end
        end
    end

    logic hs_raw;
    logic vs_raw;

    assign req_col     = h_cnt_q;
    assign req_row     = v_cnt_q;
    assign req_active  = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign line_start  = (h_cnt_q == 16'd0);
    assign frame_start = line_start && (v_cnt_q == 16'd0);
    assign hs_raw      = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
    assign vs_raw      = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);

    logic [DLY_W-1:0] dly_in;
    logic [DLY_W-1:0] dly_out;

`ifdef VGA_TEST_PATTERN_EN
    assign dly_in = {h_cnt_q, hs_raw, vs_raw, req_active};
`else
    assign dly_in = {hs_raw, vs_raw, req_active};
`endif

    // Request-side flags wait here until the drawer's colour for them arrives
    if (PIXEL_LATENCY == 0) begin : g_bypass
        assign dly_out = dly_in;
    end else begin : g_delay
        vga_delay_line #(
            .WIDTH (DLY_W),
            .DEPTH (PIXEL_LATENCY)
        ) u_delay (
            .clk   (pixel_clk),
            .reset (reset),
            .din   (dly_in),
            .dout  (dly_out)
        );
    end

    logic d_hs;
    logic d_vs;
    logic d_act;

    assign d_hs  = dly_out[2];
    assign d_vs  = dly_out[1];
    assign d_act = dly_out[0];

`ifdef VGA_TEST_PATTERN_EN
    logic [15:0] d_col;
    logic [15:0] bar_idx;
    logic [2:0]  bar_mask;

    assign d_col = dly_out[18:3];

    always_comb begin
        bar_idx = d_col / BAR_W;
        if (bar_idx > 16'd7) begin
            bar_idx = 16'd7;
        end
        bar_mask = VGA_BAR_MASK[bar_idx[2:0]];
    end
`endif

    logic                  hsync_q;
    logic                  hsync_d;
    logic                  vsync_q;
    logic                  vsync_d;
    logic [COLOR_BITS-1:0] red_q;
    logic [COLOR_BITS-1:0] red_d;
    logic [COLOR_BITS-1:0] green_q;
    logic [COLOR_BITS-1:0] green_d;
    logic [COLOR_BITS-1:0] blue_q;
    logic [COLOR_BITS-1:0] blue_d;

    always_comb begin
        hsync_d = d_hs ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_d = d_vs ? V_SYNC_POL : ~V_SYNC_POL;
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (d_act) begin
            red_d   = pix_red;
            green_d = pix_green;
            blue_d  = pix_blue;
`ifdef VGA_TEST_PATTERN_EN
            if (tp_sel) begin
                red_d   = {COLOR_BITS{bar_mask[2]}};
                green_d = {COLOR_BITS{bar_mask[1]}};
                blue_d  = {COLOR_BITS{bar_mask[0]}};
            end
`endif
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hsync_q <= ~H_SYNC_POL;
            vsync_q <= ~V_SYNC_POL;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign vga_red   = red_q;
    assign vga_green = green_q;
    assign vga_blue  = blue_q;

endmodule

// File: tb/tb_vga_timing_pipeline.sv
// tb_vga_timing_pipeline: latency-2 and latency-0 instances against an arithmetic raster model.
// Horizontal timing is the 800-cycle default; vertical is shortened to keep frames small.
module tb_vga_timing_pipeline;

    localparam int HA  = 640;
    localparam int HFP = 16;
    localparam int HSW = 96;
    localparam int HBP = 48;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VSW = 2;
    localparam int VBP = 1;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int LA  = 2;
    localparam int LB  = 0;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  a_pr, a_pg, a_pb, b_pr, b_pg, b_pb;
    logic [15:0] a_col, a_row, b_col, b_row;
    logic        a_act, a_fs, a_ls, a_hs, a_vs;
    logic        b_act, b_fs, b_ls, b_hs, b_vs;
    logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;
`ifdef VGA_TEST_PATTERN_EN
    logic        tp_sel = 1'b0;
    bit          tpm [int];
`endif

    int          vectors     = 0;
    int          miscompares = 0;
    int          n           = 0;
    int          pmode       = 0;
    int          hs_low      = 0;
    int          vs_low      = 0;
    int          last_fs     = -1;
    bit          count_en    = 1'b0;
    bit          prev_hs     = 1'b1;
    logic [11:0] colr [int];

    always #5 clk = ~clk;

    vga_timing_pipeline #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .PIXEL_LATENCY(LA)
    ) dut_a (
        .pixel_clk(clk), .reset(reset),
        .req_col(a_col), .req_row(a_row), .req_active(a_act),
        .frame_start(a_fs), .line_start(a_ls),
        .pix_red(a_pr), .pix_green(a_pg), .pix_blue(a_pb),
`ifdef VGA_TEST_PATTERN_EN
        .tp_sel(tp_sel),
`endif
        .hsync(a_hs), .vsync(a_vs),
        .vga_red(a_r), .vga_green(a_g), .vga_blue(a_b)
    );

    vga_timing_pipeline #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .PIXEL_LATENCY(LB)
    ) dut_b (
        .pixel_clk(clk), .reset(reset),
        .req_col(b_col), .req_row(b_row), .req_active(b_act),
        .frame_start(b_fs), .line_start(b_ls),
        .pix_red(b_pr), .pix_green(b_pg), .pix_blue(b_pb),
`ifdef VGA_TEST_PATTERN_EN
        .tp_sel(tp_sel),
`endif
        .hsync(b_hs), .vsync(b_vs),
        .vga_red(b_r), .vga_green(b_g), .vga_blue(b_b)
    );

    // Raster position of the k-th cycle after reset release
    function automatic int hpos(input int k);
        return k % HT;
    endfunction

    function automatic int vpos(input int k);
        return (k / HT) % VT;
    endfunction

    function automatic bit vis(input int k);
        return (hpos(k) < HA) && (vpos(k) < VA);
    endfunction

    function automatic bit hs_on(input int k);
        int h = hpos(k);
        return (h >= HA + HFP) && (h < HA + HFP + HSW);
    endfunction

    function automatic bit vs_on(input int k);
        int v = vpos(k);
        return (v >= VA + VFP) && (v < VA + VFP + VSW);
    endfunction

    function automatic logic [11:0] bar_rgb(input int col);
        case (col / (HA / 8))
            0:       return 12'hFFF;
            1:       return 12'hFF0;
            2:       return 12'h0FF;
            3:       return 12'h0F0;
            4:       return 12'hF0F;
            5:       return 12'hF00;
            6:       return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s n=%0d: observed %0h expected %0h", tag, n, got, exp);
        end
    endtask

    task automatic check_dut(
        input string       who,
        input int          lat,
        input logic [15:0] col,
        input logic [15:0] row,
        input logic        act,
        input logic        fs,
        input logic        ls,
        input logic        hs,
        input logic        vs,
        input logic [3:0]  r,
        input logic [3:0]  g,
        input logic [3:0]  b
    );
        int          s;
        logic        e_hs;
        logic        e_vs;
        logic [11:0] e_rgb;
        s     = n - lat - 1;
        e_hs  = 1'b1;
        e_vs  = 1'b1;
        e_rgb = '0;
        if (s >= 0) begin
            e_hs = !hs_on(s);
            e_vs = !vs_on(s);
            if (vis(s)) begin
                e_rgb = colr[s];
`ifdef VGA_TEST_PATTERN_EN
                if (tpm[n-1]) e_rgb = bar_rgb(hpos(s));
`endif
            end
        end
        chk({who, ".req_col"}, col, 16'(hpos(n)));
        chk({who, ".req_row"}, row, 16'(vpos(n)));
        chk({who, ".req_active"}, 16'(act), 16'(vis(n)));
        chk({who, ".line_start"}, 16'(ls), 16'(hpos(n) == 0));
        chk({who, ".frame_start"}, 16'(fs), 16'(hpos(n) == 0 && vpos(n) == 0));
        chk({who, ".hsync"}, 16'(hs), 16'(e_hs));
        chk({who, ".vsync"}, 16'(vs), 16'(e_vs));
        chk({who, ".rgb"}, {4'd0, r, g, b}, {4'd0, e_rgb});
    endtask

    // One pixel clock: check pins at negedge, drive the drawer, advance
    task automatic step();
        int          h;
        logic [11:0] c;
        check_dut("A", LA, a_col, a_row, a_act, a_fs, a_ls, a_hs, a_vs, a_r, a_g, a_b);
        check_dut("B", LB, b_col, b_row, b_act, b_fs, b_ls, b_hs, b_vs, b_r, b_g, b_b);
        if (count_en) begin
            hs_low += a_hs ? 0 : 1;
            vs_low += a_vs ? 0 : 1;
            if (prev_hs && !a_hs) begin
                chk("hsync_fall_offset", 16'((n - LA - 1) % HT), 16'(HA + HFP));
            end
        end
        prev_hs = a_hs;
        if (a_fs && !reset) begin
            if (last_fs >= 0) chk("frame_period", 16'(n - last_fs), 16'(HT * VT));
            last_fs = n;
        end
        h = hpos(n);
        case (pmode)
            0:       c = {h[3:0], 8'($urandom)};
            1:       c = 12'($urandom);
            default: c = 12'hFFF;
        endcase
        colr[n] = c;
        {b_pr, b_pg, b_pb} = c;
        if (n >= LA) {a_pr, a_pg, a_pb} = colr[n-LA];
        else         {a_pr, a_pg, a_pb} = 12'($urandom);
`ifdef VGA_TEST_PATTERN_EN
        tp_sel = (pmode == 1) ? 1'($urandom) : 1'b0;
        tpm[n] = tp_sel;
`endif
        @(posedge clk);
        if (reset) begin
            n       = 0;
            last_fs = -1;
            colr.delete();
`ifdef VGA_TEST_PATTERN_EN
            tpm.delete();
`endif
        end else begin
            n++;
        end
        @(negedge clk);
    endtask

    initial begin
        bit found;
        {a_pr, a_pg, a_pb} = '0;
        {b_pr, b_pg, b_pb} = '0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_hsync", 16'(a_hs), 16'd1);
        chk("reset_vsync", 16'(a_vs), 16'd1);
        chk("reset_rgb", {4'd0, a_r, a_g, a_b}, 16'd0);
        repeat (2) step();
        reset = 1'b0;
        chk("first_frame_start", 16'(a_fs), 16'd1);

        pmode = 0;
        repeat (100) step();
        count_en = 1'b1;
        repeat (HT * VT) step();
        count_en = 1'b0;
        chk("hsync_low_per_frame", 16'(hs_low), 16'(HSW * VT));
        chk("vsync_low_per_frame", 16'(vs_low), 16'(VSW * HT));

        pmode = 2;
        repeat (3200) step();

        pmode = 1;
        found = 1'b0;
        for (int i = 0; i < HT * VT && !found; i++) begin
            if (hpos(n) == 300 && vpos(n) == 2) found = 1'b1;
            else step();
        end
        chk("reach_h300_v2", 16'(found), 16'd1);
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        chk("post_reset_line_start", 16'(a_ls), 16'd1);
        chk("post_reset_rgb", {4'd0, a_r, a_g, a_b}, 16'd0);
        repeat (HT * VT + HT * VT / 2) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
